// File: rtl/shift_reg_3d.sv
// shift_reg_3d: three-stage fixed-latency delay line for the logical PHY datapath.
// A word captured with enable leaves stage 3 on q_o with valid_o two edges after
// capture. One word per stage can be in flight, so a new word is accepted every cycle.
module shift_reg_3d #(
   parameter int DATA_BIT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,       // asynchronous, active-low
   input  logic                      enable,
   input  logic [DATA_BIT_WIDTH-1:0] d_i,
   output logic                      enable_ack,
   output logic                      valid_o,
   output logic [DATA_BIT_WIDTH-1:0] q_o
);

   logic [DATA_BIT_WIDTH-1:0] s1_data_q, s1_data_d;
   logic [DATA_BIT_WIDTH-1:0] s2_data_q, s2_data_d;
   logic [DATA_BIT_WIDTH-1:0] s3_data_q, s3_data_d;
   logic                      s1_vld_q,  s1_vld_d;
   logic                      s2_vld_q,  s2_vld_d;
   logic                      s3_vld_q,  s3_vld_d;
   logic                      ack_q,     ack_d;

   // Next-state: valid bits always shift; data only moves along with a set valid bit.
   always_comb begin
      // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
      s1_data_d = s1_data_q;
      s2_data_d = s2_data_q;
      s3_data_d = s3_data_q;

      s1_vld_d  = enable;
      s2_vld_d  = s1_vld_q;
      s3_vld_d  = s2_vld_q;
      ack_d     = enable;

      if (enable)   s1_data_d = d_i;
      if (s1_vld_q) s2_data_d = s1_data_q;
      if (s2_vld_q) s3_data_d = s2_data_q;
   end

   // State registers: asynchronous clear discards every in-flight word at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the stage data is reset too, since q_o must read 0 immediately on reset.
         s1_data_q <= '0;
         s2_data_q <= '0;
         s3_data_q <= '0;
         s1_vld_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         s3_vld_q  <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking so every stage samples the pre-edge value of its neighbour.
         s1_data_q <= s1_data_d;
         s2_data_q <= s2_data_d;
         s3_data_q <= s3_data_d;
         s1_vld_q  <= s1_vld_d;
         s2_vld_q  <= s2_vld_d;
         s3_vld_q  <= s3_vld_d;
         ack_q     <= ack_d;
      end
   end

   assign enable_ack = ack_q;
   assign valid_o    = s3_vld_q;
   assign q_o        = s3_data_q;

endmodule

// File: tb/tb_shift_reg_3d.sv
// tb_shift_reg_3d: directed scenarios plus random traffic against a history-based
// model of the delay line (what was accepted on which edge since the last reset).
module tb_shift_reg_3d;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic [W-1:0] d_i;
   logic         enable_ack;
   logic         valid_o;
   logic [W-1:0] q_o;

   int n_checks = 0;
   int n_errors = 0;

   shift_reg_3d #(.DATA_BIT_WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .d_i        (d_i),
      .enable_ack (enable_ack),
      .valid_o    (valid_o),
      .q_o        (q_o)
   );

   always #5 clk = ~clk;

   // Model: everything sampled on each rising edge since reset was last released.
   logic         en_h[$];
   logic [W-1:0] d_h[$];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_h.delete();
         d_h.delete();
      end else begin
         en_h.push_back(enable);
         d_h.push_back(d_i);
      end
   end

   function automatic logic exp_ack();
      return (en_h.size() > 0) ? en_h[en_h.size()-1] : 1'b0;
   endfunction

   // A word sampled on edge k is on the output after edge k+2.
   function automatic logic exp_valid();
      return (en_h.size() >= 3) ? en_h[en_h.size()-3] : 1'b0;
   endfunction

   // Output holds the most recent word that has reached the output.
   function automatic logic [W-1:0] exp_q();
      for (int i = en_h.size() - 3; i >= 0; i--)
         if (en_h[i]) return d_h[i];
      return '0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Single compare process: every falling clock edge and right after any reset assertion.
   always begin
      @(negedge clk or negedge reset);
      #1;
      check("model_ack",   {31'b0, enable_ack}, {31'b0, exp_ack()});
      check("model_valid", {31'b0, valid_o},    {31'b0, exp_valid()});
      check("model_q",     {24'b0, q_o},        {24'b0, exp_q()});
   end

   // One cycle: sample point (optional literal pins of the model), then drive next inputs.
   task automatic step(input logic en, input logic [W-1:0] d, input logic chk,
                       input logic e_ack, input logic e_v, input logic [W-1:0] e_q);
      @(negedge clk);
      #1;
      if (chk) begin
         check("lit_ack",   {31'b0, enable_ack}, {31'b0, e_ack});
         check("lit_valid", {31'b0, valid_o},    {31'b0, e_v});
         check("lit_q",     {24'b0, q_o},        {24'b0, e_q});
      end
      #1;
      enable = en;
      d_i    = d;
   endtask

   initial begin
      // Reset held with enable high and data all ones.
      reset = 1'b0; enable = 1'b1; d_i = 8'hFF;
      step(1, 8'hFF, 1, 0, 0, 8'h00);
      step(1, 8'hFF, 1, 0, 0, 8'h00);
      step(0, 8'h00, 1, 0, 0, 8'h00);
      reset = 1'b1;
      step(0, 8'h00, 1, 0, 0, 8'h00);
      step(0, 8'h00, 1, 0, 0, 8'h00);
      step(0, 8'h00, 1, 0, 0, 8'h00);

      // Single word.
      step(1, 8'hAA, 1, 0, 0, 8'h00);
      step(0, 8'h00, 1, 1, 0, 8'h00);
      step(0, 8'h00, 1, 0, 0, 8'h00);
      step(0, 8'h00, 1, 0, 1, 8'hAA);
      step(0, 8'h00, 1, 0, 0, 8'hAA);

      // Second word, same latency.
      step(1, 8'h66, 1, 0, 0, 8'hAA);
      step(0, 8'h00, 1, 1, 0, 8'hAA);
      step(0, 8'h00, 1, 0, 0, 8'hAA);
      step(0, 8'h00, 1, 0, 1, 8'h66);
      step(0, 8'h00, 1, 0, 0, 8'h66);

      // Back-to-back words.
      step(1, 8'h01, 1, 0, 0, 8'h66);
      step(1, 8'h02, 1, 1, 0, 8'h66);
      step(1, 8'h03, 1, 1, 0, 8'h66);
      step(0, 8'h00, 1, 1, 1, 8'h01);
      step(0, 8'h00, 1, 0, 1, 8'h02);
      step(0, 8'h00, 1, 0, 1, 8'h03);
      step(0, 8'h00, 1, 0, 0, 8'h03);

      // Data ignored while enable is low.
      for (int i = 0; i < 6; i++)
         step(0, W'($urandom), 1, 0, 0, 8'h03);

      // Reset mid-flight, asserted between clock edges.
      step(1, 8'hAA, 1, 0, 0, 8'h03);
      step(0, 8'h00, 1, 1, 0, 8'h03);
      #1;
      reset = 1'b0;
      #1;
      check("rst_ack",   {31'b0, enable_ack}, 32'h0);
      check("rst_valid", {31'b0, valid_o},    32'h0);
      check("rst_q",     {24'b0, q_o},        32'h0);
      step(0, 8'h00, 1, 0, 0, 8'h00);
      step(0, 8'h00, 1, 0, 0, 8'h00);
      reset = 1'b1;
      for (int i = 0; i < 5; i++)
         step(0, 8'h00, 1, 0, 0, 8'h00);

      // Random traffic with occasional asynchronous resets; the compare process checks it.
      for (int i = 0; i < 400; i++) begin
         step(logic'($urandom_range(0, 2) != 0), W'($urandom), 0, 0, 0, 8'h00);
         if (i % 97 == 50) begin
            #($urandom_range(1, 4));
            reset = 1'b0;
            step(0, 8'h00, 0, 0, 0, 8'h00);
            reset = 1'b1;
         end
      end
      step(0, 8'h00, 0, 0, 0, 8'h00);
      step(0, 8'h00, 0, 0, 0, 8'h00);
      step(0, 8'h00, 0, 0, 0, 8'h00);
      @(negedge clk);
      #2;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
